alu_reg_sequencer: RTL
======================

// Module: alu_reg_sequencer
// PURPOSE
//  Multi-cycle control unit for the ALU/register-bank/data-memory datapath. It accepts one
//  48-bit instruction through a valid/ready handshake, then drives the datapath's control
//  inputs for 1-2 cycles per instruction: register selects, ALU op, shifter, immediate mux
//  and memory strobes. It keeps an architectural carry flag. It sits between the
//  fetch/issue logic and the datapath.
// PARAMETERS
//  PARK_SEL  6'd63  C_SEL_RB code that writes no register; driven whenever no write is due
//  INSTR_W   48     instruction width; fixed, since the field map below assumes 48
// PORTS
//  CLK          in   1   clock; all state changes on the rising edge
//  RST_N        in   1   asynchronous reset, active-low
//  INSTR_VALID  in   1   issuer has an instruction on INSTR
//  INSTR_READY  out  1   sequencer can accept; high only in IDLE
//  INSTR        in   48  instruction word, captured when VALID & READY
//  CY_OUT       in   1   carry out of the datapath ALU
//  SEL_A_RB     out  6   register-bank read port A select
//  SEL_B_RB     out  6   register-bank read port B select
//  C_SEL_RB     out  6   register-bank write select; PARK_SEL = no write
//  ALUC_IN      out  4   ALU operation code
//  CY_IN        out  1   ALU carry in
//  Shifter_Sel  out  2   shifter mode
//  Y_X_Kmx_Sel  out  1   0 = B operand from register, 1 = immediate Y_KMx_IN
//  Y_KMx_IN     out  16  immediate operand
//  DAddr        out  10  data-memory address
//  MR / MW      out  1   data-memory read / write strobes
//  BUSY         out  1   instruction in progress (state != IDLE)
//  DONE         out  1   one-cycle pulse in the last active cycle of an instruction
//  CY_FLAG      out  1   architectural carry flag
// BEHAVIOUR
//  Field map: [47:46] TYPE (00 ALU reg-reg, 01 ALU reg-imm, 10 LOAD, 11 STORE);
//   [45:42] ALUC; [41:40] SHIFT; [39] CYM; [38:33] C; [32:27] A; [26:21] B;
//   [20:16] reserved, ignored; [15:0] IMM. DAddr = IMM[9:0].
//  Reset (async, RST_N=0): state=IDLE, IR=0, CY_FLAG=0, INSTR_READY=1, BUSY=0, DONE=0.
//   All selects, ALUC_IN, Shifter_Sel, Y_X_Kmx_Sel, Y_KMx_IN, DAddr, MR, MW and CY_IN
//   are 0, except C_SEL_RB=PARK_SEL. These are also the idle/park values.
//  Control outputs decode from state + IR register only; no combinational INSTR->output path.
//  FSM states: IDLE, EXEC, MEM_RD, MEM_WB, MEM_WR.
//   IDLE:   READY=1; on VALID, capture IR, then go to EXEC (TYPE 0x), MEM_RD (10) or MEM_WR (11).
//   EXEC:   SEL_A=A, SEL_B=B, C_SEL=C, ALUC_IN=ALUC, Shifter_Sel=SHIFT.
//           Y_X_Kmx_Sel=TYPE[0]; Y_KMx_IN=IMM when TYPE=01, else 0.
//           CY_IN = CYM ? CY_FLAG : 0.
//           DONE=1; at the clock edge CY_FLAG<=CY_OUT; go to IDLE.
//   MEM_RD: MR=1, DAddr=addr, C_SEL=PARK_SEL; go to MEM_WB.
//   MEM_WB: MR=1, DAddr=addr, C_SEL=C, Y_X_Kmx_Sel=0; DONE=1; go to IDLE.
//   MEM_WR: MW=1, DAddr=addr, SEL_A=A (store data source), C_SEL=PARK_SEL; DONE=1; go to IDLE.
//  Latency after the accept edge: ALU 1 cycle, LOAD 2, STORE 1. READY returns the cycle
//   after DONE, so maximum issue rate is one ALU instruction per 2 cycles.
//  CY_FLAG changes only on EXEC edges; LOAD and STORE leave it unchanged.
//  VALID while BUSY: ignored, nothing captured; the issuer must hold INSTR and VALID.
//  MR and MW are never both 1; MW is high for exactly one cycle per STORE.
//  Reset mid-instruction: outputs park immediately; an interrupted STORE or LOAD is
//   abandoned with no further MW/MR pulse and no DONE.
//  Reserved bits do not affect behaviour.
// TESTING
//  1 Reset: RST_N=0 mid-MEM_RD -> same cycle MR=0, C_SEL_RB=63, READY=1, CY_FLAG=0.
//  2 ALU rr: TYPE00 ALUC=4'h3 C=5 A=1 B=2, VALID 1 cycle -> next cycle SEL_A=1 SEL_B=2
//     C_SEL=5 ALUC_IN=3 Y_X_Kmx_Sel=0 DONE=1; following cycle READY=1, C_SEL=63.
//  3 Carry chain: ALU with CY_OUT forced 1, then ALU with CYM=1 -> second EXEC has CY_IN=1;
//     repeat with CYM=0 -> CY_IN=0.
//  4 Reg-imm: TYPE01 IMM=16'hBEEF -> EXEC has Y_X_Kmx_Sel=1 and Y_KMx_IN=BEEF.
//  5 LOAD C=7 IMM=16'h0123 -> MR=1 DAddr=10'h123 for 2 cycles; C_SEL=63 then 7;
//     DONE only in the 2nd cycle.
//  6 STORE A=9 IMM=16'h03FF, VALID held through BUSY -> one MW pulse with DAddr=3FF and
//     SEL_A=9; CY_FLAG unchanged; same instruction re-accepted only when READY=1.

Source files
------------

// File: rtl/alu_reg_sequencer.sv
// ---------------------------------------------------------------------------
// alu_reg_sequencer
//
// Multi-cycle control unit for the ALU / register-bank / data-memory datapath.
// Accepts one 48-bit instruction per handshake and then drives the datapath
// control inputs for 1 (ALU, STORE) or 2 (LOAD) cycles.  It also keeps the
// architectural carry flag.
//
// Handshake: an instruction is captured on a rising CLK edge where
// INSTR_VALID and INSTR_READY are both high.  INSTR_READY is high only in
// IDLE.  VALID seen while BUSY is ignored; the issuer holds INSTR/VALID until
// it is accepted.
//
// Ports
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   INSTR_VALID/READY instruction handshake
//   INSTR             instruction word
//   CY_OUT            carry out of the datapath ALU
//   SEL_A_RB/SEL_B_RB register-bank read selects
//   C_SEL_RB          register-bank write select (PARK_SEL = no write)
//   ALUC_IN, CY_IN    ALU op code and carry in
//   Shifter_Sel       shifter mode
//   Y_X_Kmx_Sel       B operand mux (0 register, 1 immediate Y_KMx_IN)
//   Y_KMx_IN          immediate operand
//   DAddr, MR, MW     data-memory address and read/write strobes
//   BUSY, DONE        in-progress flag, last-active-cycle pulse
//   CY_FLAG           architectural carry flag
//   state_dbg         current FSM state, for observation only
// ---------------------------------------------------------------------------
module alu_reg_sequencer #(
  parameter logic [5:0] PARK_SEL = 6'd63,
  parameter int         INSTR_W  = 48
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               INSTR_VALID,
  output logic               INSTR_READY,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               CY_OUT,
  output logic [5:0]         SEL_A_RB,
  output logic [5:0]         SEL_B_RB,
  output logic [5:0]         C_SEL_RB,
  output logic [3:0]         ALUC_IN,
  output logic               CY_IN,
  output logic [1:0]         Shifter_Sel,
  output logic               Y_X_Kmx_Sel,
  output logic [15:0]        Y_KMx_IN,
  output logic [9:0]         DAddr,
  output logic               MR,
  output logic               MW,
  output logic               BUSY,
  output logic               DONE,
  output logic               CY_FLAG,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXEC   = 3'd1,
    MEM_RD = 3'd2,
    MEM_WB = 3'd3,
    MEM_WR = 3'd4
  } state_t;

  state_t state, state_nx;

  // Only the meaningful fields are held: [47:21] and [15:0].
  // The reserved field [20:16] never reaches any logic.
  logic [26:0] ir_hi;
  logic [15:0] ir_imm;
  logic        unused_rsv;

  assign unused_rsv = ^INSTR[20:16];

  logic [1:0] f_type;
  logic [3:0] f_aluc;
  logic [1:0] f_shift;
  logic       f_cym;
  logic [5:0] f_c;
  logic [5:0] f_a;
  logic [5:0] f_b;

  assign f_type  = ir_hi[26:25];
  assign f_aluc  = ir_hi[24:21];
  assign f_shift = ir_hi[20:19];
  assign f_cym   = ir_hi[18];
  assign f_c     = ir_hi[17:12];
  assign f_a     = ir_hi[11:6];
  assign f_b     = ir_hi[5:0];

  logic accept;
  assign accept = (state == IDLE) && INSTR_VALID;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      ir_hi   <= '0;
      ir_imm  <= '0;
      CY_FLAG <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        ir_hi  <= INSTR[47:21];
        ir_imm <= INSTR[15:0];
      end
      // The carry flag is architectural state of ALU ops only.
      if (state == EXEC) begin
        CY_FLAG <= CY_OUT;
      end
    end
  end

  // Next state from state + INSTR type; every control output comes from
  // state + registered IR only, so nothing on INSTR reaches the datapath
  // combinationally.
  always_comb begin
    state_nx    = state;
    INSTR_READY = 1'b0;
    SEL_A_RB    = '0;
    SEL_B_RB    = '0;
    C_SEL_RB    = PARK_SEL;
    ALUC_IN     = '0;
    CY_IN       = 1'b0;
    Shifter_Sel = '0;
    Y_X_Kmx_Sel = 1'b0;
    Y_KMx_IN    = '0;
    DAddr       = '0;
    MR          = 1'b0;
    MW          = 1'b0;
    DONE        = 1'b0;

    case (state)
      IDLE: begin
        INSTR_READY = 1'b1;
        if (INSTR_VALID) begin
          case (INSTR[47:46])
            2'b10:   state_nx = MEM_RD;
            2'b11:   state_nx = MEM_WR;
            default: state_nx = EXEC;
          endcase
        end
      end
      EXEC: begin
        SEL_A_RB    = f_a;
        SEL_B_RB    = f_b;
        C_SEL_RB    = f_c;
        ALUC_IN     = f_aluc;
        Shifter_Sel = f_shift;
        Y_X_Kmx_Sel = f_type[0];
        Y_KMx_IN    = (f_type == 2'b01) ? ir_imm : 16'h0000;
        CY_IN       = f_cym & CY_FLAG;
        DONE        = 1'b1;
        state_nx    = IDLE;
      end
      MEM_RD: begin
        // Address phase: the register write is held off until data returns.
        MR       = 1'b1;
        DAddr    = ir_imm[9:0];
        state_nx = MEM_WB;
      end
      MEM_WB: begin
        MR       = 1'b1;
        DAddr    = ir_imm[9:0];
        C_SEL_RB = f_c;
        DONE     = 1'b1;
        state_nx = IDLE;
      end
      MEM_WR: begin
        // Port A carries the store data to memory.
        MW       = 1'b1;
        DAddr    = ir_imm[9:0];
        SEL_A_RB = f_a;
        DONE     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign BUSY      = (state != IDLE);
  assign state_dbg = state;

endmodule
